// File: rtl/rescale_nn_stream.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | rescale_nn_stream: streaming nearest-neighbour stamp rescaler (AXI-Stream)  |
// | Optional macro RESCALE_SOF_TUSER_EN drives start-of-frame on M_AXIS_TUSER.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module rescale_nn_stream #(
    parameter int DATA_W = 32,
    parameter int DIM_W  = 10,
    parameter int MAX_W  = 640,
    parameter int MAX_H  = 1023
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              GO,
    input  logic [DIM_W-1:0]  SRC_W,
    input  logic [DIM_W-1:0]  SRC_H,
    input  logic [DIM_W-1:0]  X_IN,
    input  logic [DIM_W-1:0]  Y_IN,
    output logic              DONE,
    output logic              ERROR,
    input  logic [DATA_W-1:0] S_AXIS_TDATA,
    input  logic              S_AXIS_TVALID,
    input  logic              S_AXIS_TLAST,
    output logic              S_AXIS_TREADY,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TVALID,
    output logic              M_AXIS_TLAST,
    output logic              M_AXIS_TUSER,
    input  logic              M_AXIS_TREADY
);
    localparam int PW = 2*DIM_W + 1;
    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [DIM_W-1:0] DIM_ONE  = DIM_W'(1);
    localparam logic [DIM_W:0]   MAX_W_EXT = (DIM_W+1)'(MAX_W);
    localparam logic [DIM_W:0]   MAX_H_EXT = (DIM_W+1)'(MAX_H);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_CAPTURE = 3'd2,
        S_EMIT    = 3'd3,
        S_DONE    = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [DIM_W-1:0]   src_w_q, src_w_d, src_h_q, src_h_d, x_in_q, x_in_d, y_in_q, y_in_d;
    logic [DIM_W-1:0]   sx_q, sx_d, dx_q, dx_d, sy_q, sy_d, dy_q, dy_d, ex_q, ex_d;
    logic [PW-1:0]      px_q, px_d, qx_q, qx_d, py_q, py_d, qy_q, qy_d;
    logic               hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0]  hold_data_q, hold_data_d;
    logic               rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic               m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [DATA_W-1:0]  m_data_q, m_data_d;
    logic [DATA_W-1:0]  rd_data_q;
    logic [DATA_W-1:0]  line_buf [0:MAX_W-1];

    logic               wr_en, rd_issue, s_ready, o_load, m_hs, row_last, next_src_row, cfg_bad;
    logic [DIM_W:0]     x_in_ext, y_in_ext, src_h_port_ext;
    logic [PW-1:0]      src_w_pw, src_h_pw, x_in_pw, y_in_pw;

    assign x_in_ext       = {1'b0, X_IN};
    assign y_in_ext       = {1'b0, Y_IN};
    assign src_h_port_ext = {1'b0, SRC_H};
    assign cfg_bad  = (SRC_W == '0) || (SRC_H == '0) || (X_IN == '0) || (Y_IN == '0) ||
                      (x_in_ext > MAX_W_EXT) || (y_in_ext > MAX_H_EXT) || (src_h_port_ext > MAX_H_EXT);
    assign src_w_pw = PW'(src_w_q);
    assign src_h_pw = PW'(src_h_q);
    assign x_in_pw  = PW'(x_in_q);
    assign y_in_pw  = PW'(y_in_q);
    assign row_last = (sx_q == (src_w_q - DIM_ONE));

`ifdef RESCALE_SOF_TUSER_EN
    logic rd_user_q, rd_user_d, m_user_q, m_user_d;
`endif

    always_comb begin
        state_d      = state_q;
        src_w_d      = src_w_q;
        src_h_d      = src_h_q;
        x_in_d       = x_in_q;
        y_in_d       = y_in_q;
        sx_d         = sx_q;
        dx_d         = dx_q;
        sy_d         = sy_q;
        dy_d         = dy_q;
        ex_d         = ex_q;
        px_d         = px_q;
        qx_d         = qx_q;
        py_d         = py_q;
        qy_d         = qy_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        rd_valid_d   = rd_valid_q;
        rd_last_d    = rd_last_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        m_data_d     = m_data_q;
`ifdef RESCALE_SOF_TUSER_EN
        rd_user_d    = rd_user_q;
        m_user_d     = m_user_q;
`endif
        wr_en        = 1'b0;
        rd_issue     = 1'b0;
        s_ready      = 1'b0;
        next_src_row = 1'b0;

        // Two-stage read pipeline: buffer read register feeds the output register.
        m_hs   = m_valid_q && M_AXIS_TREADY;
        o_load = rd_valid_q && (!m_valid_q || M_AXIS_TREADY);
        if (m_hs) m_valid_d = 1'b0;
        if (o_load) begin
            m_valid_d  = 1'b1;
            m_data_d   = rd_data_q;
            m_last_d   = rd_last_q;
            rd_valid_d = 1'b0;
`ifdef RESCALE_SOF_TUSER_EN
            m_user_d   = rd_user_q;
`endif
        end

        case (state_q)
            S_IDLE: if (GO) state_d = S_CHECK;
            S_CHECK: begin
                src_w_d      = SRC_W;
                src_h_d      = SRC_H;
                x_in_d       = X_IN;
                y_in_d       = Y_IN;
                sx_d         = '0;
                dx_d         = '0;
                sy_d         = '0;
                dy_d         = '0;
                ex_d         = '0;
                px_d         = '0;
                py_d         = '0;
                qx_d         = PW'(X_IN);
                qy_d         = PW'(Y_IN);
                hold_valid_d = 1'b0;
                state_d      = cfg_bad ? S_ERROR : S_CAPTURE;
            end
            S_CAPTURE: begin
                s_ready = !hold_valid_q;
                if (!hold_valid_q) begin
                    if (S_AXIS_TVALID) begin
                        if (S_AXIS_TLAST != row_last) begin
                            state_d = S_ERROR;
                        end else begin
                            hold_valid_d = 1'b1;
                            hold_data_d  = S_AXIS_TDATA;
                        end
                    end
                end else if (px_q < qx_q) begin
                    wr_en = 1'b1;
                    dx_d  = dx_q + DIM_ONE;
                    px_d  = px_q + src_w_pw;
                end else begin
                    hold_valid_d = 1'b0;
                    if (!row_last) begin
                        sx_d = sx_q + DIM_ONE;
                        qx_d = qx_q + x_in_pw;
                    end else if (py_q < qy_q) begin
                        state_d = S_EMIT;
                        ex_d    = '0;
                    end else begin
                        next_src_row = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if ((ex_q < x_in_q) && (!rd_valid_q || o_load)) begin
                    rd_issue   = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (ex_q == (x_in_q - DIM_ONE));
                    ex_d       = ex_q + DIM_ONE;
`ifdef RESCALE_SOF_TUSER_EN
                    rd_user_d  = (dy_q == '0) && (ex_q == '0);
`endif
                end
                if (m_hs && m_last_q) begin
                    dy_d = dy_q + DIM_ONE;
                    py_d = py_q + src_h_pw;
                    if (((py_q + src_h_pw) < qy_q) && ((dy_q + DIM_ONE) < y_in_q)) ex_d = '0;
                    else next_src_row = 1'b1;
                end
            end
            S_DONE, S_ERROR: if (!GO) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (next_src_row) begin
            sy_d    = sy_q + DIM_ONE;
            qy_d    = qy_q + y_in_pw;
            sx_d    = '0;
            dx_d    = '0;
            px_d    = '0;
            qx_d    = x_in_pw;
            state_d = ((sy_q + DIM_ONE) == src_h_q) ? S_DONE : S_CAPTURE;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            src_w_q      <= '0;
            src_h_q      <= '0;
            x_in_q       <= '0;
            y_in_q       <= '0;
            sx_q         <= '0;
            dx_q         <= '0;
            sy_q         <= '0;
            dy_q         <= '0;
            ex_q         <= '0;
            px_q         <= '0;
            qx_q         <= '0;
            py_q         <= '0;
            qy_q         <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            src_w_q      <= src_w_d;
            src_h_q      <= src_h_d;
            x_in_q       <= x_in_d;
            y_in_q       <= y_in_d;
            sx_q         <= sx_d;
            dx_q         <= dx_d;
            sy_q         <= sy_d;
            dy_q         <= dy_d;
            ex_q         <= ex_d;
            px_q         <= px_d;
            qx_q         <= qx_d;
            py_q         <= py_d;
            qy_q         <= qy_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_data_q     <= m_data_d;
        end
    end

    // Line buffer has no reset so it can map onto block RAM.
    always_ff @(posedge CLOCK) begin
        if (wr_en)    line_buf[AW'(dx_q)] <= hold_data_q;
        if (rd_issue) rd_data_q           <= line_buf[AW'(ex_q)];
    end

`ifdef RESCALE_SOF_TUSER_EN
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            rd_user_q <= 1'b0;
            m_user_q  <= 1'b0;
        end else begin
            rd_user_q <= rd_user_d;
            m_user_q  <= m_user_d;
        end
    end
    assign M_AXIS_TUSER = m_user_q;
`else
    assign M_AXIS_TUSER = 1'b0;
`endif

    assign S_AXIS_TREADY = s_ready;
    assign DONE          = (state_q == S_DONE);
    assign ERROR         = (state_q == S_ERROR);
    assign M_AXIS_TVALID = m_valid_q;
    assign M_AXIS_TDATA  = m_data_q;
    assign M_AXIS_TLAST  = m_last_q;
endmodule
`default_nettype wire

// File: tb/tb_rescale_nn_stream.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_rescale_nn_stream: self-checking bench for rescale_nn_stream             |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_rescale_nn_stream;
    localparam int DATA_W = 32;
    localparam int DIM_W  = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              go = 1'b0;
    logic [DIM_W-1:0]  src_w = '0, src_h = '0, x_in = '0, y_in = '0;
    logic              done, error;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid, m_last, m_user;
    logic              m_ready = 1'b0;

    always #5 clk = ~clk;

    rescale_nn_stream dut (
        .CLOCK(clk), .RESET(rst), .GO(go),
        .SRC_W(src_w), .SRC_H(src_h), .X_IN(x_in), .Y_IN(y_in),
        .DONE(done), .ERROR(error),
        .S_AXIS_TDATA(s_data), .S_AXIS_TVALID(s_valid), .S_AXIS_TLAST(s_last), .S_AXIS_TREADY(s_ready),
        .M_AXIS_TDATA(m_data), .M_AXIS_TVALID(m_valid), .M_AXIS_TLAST(m_last), .M_AXIS_TUSER(m_user),
        .M_AXIS_TREADY(m_ready)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              user;
    } beat_t;

    typedef struct {
        int sw, sh, xi, yi;
        int vmode;    // 0 always valid, 1 random
        int rmode;    // 0 always ready, 1 random, 2 toggle 1,0
        int bad_col;  // column carrying a wrong TLAST in row 0, -1 for none
        int exp_err;  // 0 none, 1 framing, 2 config
    } vec_t;

    int                checks = 0;
    int                failures = 0;
    logic [DATA_W-1:0] src_pix [$];
    beat_t             exp_q [$];
    logic [DATA_W-1:0] got [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Reference: every destination pixel picks source floor(d*S/D) on each axis.
    task automatic build_frame(input int sw, sh, xi, yi, input bit rnd, input bit with_exp);
        beat_t b;
        src_pix.delete();
        exp_q.delete();
        got.delete();
        for (int r = 0; r < sh; r++)
            for (int c = 0; c < sw; c++)
                src_pix.push_back(rnd ? DATA_W'($urandom) : DATA_W'(r*sw + c));
        if (!with_exp) return;
        for (int dy = 0; dy < yi; dy++)
            for (int dx = 0; dx < xi; dx++) begin
                b.data = src_pix[(dy*sh/yi)*sw + (dx*sw/xi)];
                b.last = (dx == xi-1);
`ifdef RESCALE_SOF_TUSER_EN
                b.user = (dx == 0) && (dy == 0);
`else
                b.user = 1'b0;
`endif
                exp_q.push_back(b);
            end
    endtask

    task automatic run_frame(input int sw, sh, xi, yi, vmode, rmode, bad_col, exp_err,
                             input int abort_beats, input bit rnd, input string tag);
        int total, sidx, beats, s_cnt, col;
        bit stall, bad_pending, aborted;
        logic [DATA_W-1:0] st_data;
        logic st_last;
        beat_t e;
        total = sw*sh; sidx = 0; beats = 0; s_cnt = 0;
        stall = 0; bad_pending = 0; aborted = 0; st_data = '0; st_last = 0;
        build_frame(sw, sh, xi, yi, rnd, exp_err == 0);
        src_w = DIM_W'(sw); src_h = DIM_W'(sh); x_in = DIM_W'(xi); y_in = DIM_W'(yi);
        @(negedge clk);
        go = 1'b1;
        for (int cyc = 0; cyc < 30000; cyc++) begin
            @(negedge clk);
            if (bad_pending) begin
                check({tag, " err_next_cycle"}, {error, s_ready}, 2'b10);
                break;
            end
            if (stall)
                check({tag, " stall_hold"}, {m_valid, m_last, m_data}, {1'b1, st_last, st_data});
            if (done || error) break;
            if (abort_beats >= 0 && beats >= abort_beats) begin aborted = 1; break; end
            col     = (sw > 0) ? sidx % sw : 0;
            s_valid = (sidx < total) && (vmode == 0 || $urandom_range(0, 1) == 1);
            s_data  = (sidx < total) ? src_pix[sidx] : '0;
            s_last  = (bad_col >= 0 && sidx < sw) ? (col == bad_col) : (col == sw-1);
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 2) != 0);
                default: m_ready = (cyc % 2 == 0);
            endcase
            if (s_valid && s_ready) begin
                s_cnt++;
                if (s_last != (col == sw-1)) bad_pending = 1;
                sidx++;
            end
            if (m_valid && m_ready) begin
                beats++;
                got.push_back(m_data);
                if (exp_q.size() == 0) begin
                    check({tag, " extra_beat"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("%s beat%0d", tag, beats), {m_user, m_last, m_data}, {e.user, e.last, e.data});
                end
            end
            stall   = m_valid && !m_ready;
            st_data = m_data;
            st_last = m_last;
        end
        s_valid = 1'b0;
        if (aborted) return;
        if (exp_err == 0) begin
            check({tag, " done"}, {done, error}, 2'b10);
            check({tag, " beats_left"}, exp_q.size(), 0);
            check({tag, " src_used"}, sidx, total);
            check({tag, " no_tready_after_done"}, s_ready, 0);
        end else begin
            check({tag, " error_flag"}, {done, error}, 2'b01);
            check({tag, " no_tready_after_err"}, s_ready, 0);
            check({tag, " no_m_beats"}, beats, 0);
            if (exp_err == 2) check({tag, " no_s_beats"}, s_cnt, 0);
        end
        go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({tag, " back_idle"}, {done, error}, 2'b00);
    endtask

    vec_t        tbl [10];
    logic [31:0] k55 [15];
    logic [31:0] k48 [8];

    initial begin
        tbl[0] = '{8, 8, 5, 5, 0, 0, -1, 0};
        tbl[1] = '{4, 4, 8, 8, 0, 0, -1, 0};
        tbl[2] = '{8, 8, 5, 5, 0, 2, -1, 0};
        tbl[3] = '{8, 8, 5, 5, 0, 0, 5, 1};
        tbl[4] = '{8, 8, 5, 5, 1, 1, -1, 0};
        tbl[5] = '{8, 8, 0, 5, 0, 0, -1, 2};
        tbl[6] = '{8, 8, 641, 5, 0, 0, -1, 2};
        tbl[7] = '{8, 0, 5, 5, 0, 0, -1, 2};
        tbl[8] = '{2, 1, 640, 1, 0, 1, -1, 0};
        tbl[9] = '{1, 1, 1, 1, 1, 1, -1, 0};
        k55 = '{0, 1, 3, 4, 6, 8, 9, 11, 12, 14, 48, 49, 51, 52, 54};
        k48 = '{0, 0, 1, 1, 2, 2, 3, 3};

        repeat (2) @(negedge clk);
        check("reset_outputs", {done, error, s_ready, m_valid, m_last, m_user, m_data},
              {6'b0, {DATA_W{1'b0}}});
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", {done, error, s_ready, m_valid}, 4'b0);

        for (int i = 0; i < 10; i++) begin
            run_frame(tbl[i].sw, tbl[i].sh, tbl[i].xi, tbl[i].yi, tbl[i].vmode, tbl[i].rmode,
                      tbl[i].bad_col, tbl[i].exp_err, -1, 1'b0, $sformatf("vec%0d", i));
            if (i == 0 && got.size() == 25)
                for (int j = 0; j < 15; j++)
                    check($sformatf("k55_%0d", j), got[(j < 10) ? j : j + 10], k55[j]);
            if (i == 1 && got.size() == 64)
                for (int j = 0; j < 8; j++)
                    check($sformatf("k48_%0d", j), got[j], k48[j]);
        end

        for (int i = 0; i < 8; i++)
            run_frame($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 12),
                      $urandom_range(1, 12), 1, 1, -1, 0, -1, 1'b1, $sformatf("rnd%0d", i));

        // Asynchronous reset while the second destination row is streaming.
        run_frame(8, 8, 5, 5, 0, 0, -1, 0, 7, 1'b0, "abort");
        #1 rst = 1'b1;
        #1 check("reset_mid_emit", {done, error, s_ready, m_valid, m_last, m_user, m_data},
                 {6'b0, {DATA_W{1'b0}}});
        go = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_frame(8, 8, 5, 5, 1, 1, -1, 0, -1, 1'b1, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
